// File: rtl/pe_mac_ws_dbuf.sv
// pe_mac_ws_dbuf: weight-stationary systolic MAC processing element.
//   Double-buffered weight (shadow shifts in while active computes),
//   2-stage pipeline (multiply, then add), per-sample psum source select,
//   signed/unsigned operands, valid tracking.
//   Optional saturating accumulator: define PE_SAT_EN. Without it the add
//   wraps modulo 2^ACC_W and sat_flag stays 0.
// Ports:
//   clk, rst (sync, active-high), en (global advance; 0 holds everything)
//   w_load/w_in  -> shadow weight, w_swap -> active <= shadow, w_out = shadow
//   in_valid, pixel_in, psum_in, psum_mem_in, psum_sel, clr -> stage 1
//   pixel_out/pixel_valid_out (1 cycle), psum_out/psum_valid_out/sat_flag (2 cycles)
module pe_mac_ws_dbuf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_swap,
  output logic [DATA_W-1:0] w_out,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic [ACC_W-1:0]  psum_mem_in,
  input  logic              psum_sel,
  input  logic              clr,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  output logic              sat_flag
);

  // One guard bit per operand keeps the unsigned case exact in a signed multiply.
  localparam int unsigned PROD_W = 2 * DATA_W + 2;

  logic [DATA_W-1:0]        w_act;
  logic [DATA_W-1:0]        w_sh;
  logic [ACC_W-1:0]         prod_r;
  logic [ACC_W-1:0]         addend_r;

  logic signed [PROD_W-1:0] pix_ext_c;
  logic signed [PROD_W-1:0] w_ext_c;
  logic signed [PROD_W-1:0] prod_full_c;
  logic [ACC_W-1:0]         prod_acc_c;
  logic [ACC_W-1:0]         addend_c;
  logic [ACC_W-1:0]         sum_c;
  logic                     sat_c;

  assign w_out = w_sh;

  // Operand extension: sign- or zero-extend before the multiply.
  always_comb begin
    pix_ext_c = '0;
    w_ext_c   = '0;
    if (SIGNED != 0) begin
      pix_ext_c = PROD_W'($signed(pixel_in));
      w_ext_c   = PROD_W'($signed(w_act));
    end else begin
      pix_ext_c = PROD_W'(pixel_in);
      w_ext_c   = PROD_W'(w_act);
    end
  end

  assign prod_full_c = pix_ext_c * w_ext_c;
  // Signed cast: sign-extends in signed mode, zero-extends (non-negative) otherwise.
  assign prod_acc_c  = ACC_W'(prod_full_c);

  // Addend select: clr wins over psum_sel.
  always_comb begin
    addend_c = psum_in;
    if (clr)           addend_c = '0;
    else if (psum_sel) addend_c = psum_mem_in;
  end

`ifdef PE_SAT_EN
  logic [ACC_W:0] sum_wide_c;

  // Stage-2 adder with clamp on overflow.
  always_comb begin
    sum_wide_c = {1'b0, addend_r} + {1'b0, prod_r};
    sum_c      = sum_wide_c[ACC_W-1:0];
    sat_c      = 1'b0;
    if (SIGNED != 0) begin
      if ((addend_r[ACC_W-1] == prod_r[ACC_W-1]) &&
          (sum_wide_c[ACC_W-1] != addend_r[ACC_W-1])) begin
        sat_c = 1'b1;
        sum_c = addend_r[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum_wide_c[ACC_W]) begin
      sat_c = 1'b1;
      sum_c = '1;
    end
  end
`else
  // Stage-2 adder, wraps modulo 2^ACC_W.
  assign sum_c = addend_r + prod_r;
  assign sat_c = 1'b0;
`endif

  // Weight buffers and both pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_act           <= '0;
      w_sh            <= '0;
      prod_r          <= '0;
      addend_r        <= '0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      psum_out        <= '0;
      psum_valid_out  <= 1'b0;
      sat_flag        <= 1'b0;
    end else if (en) begin
      if (w_swap) w_act <= w_sh;
      if (w_load) w_sh  <= w_in;
      // pixel_valid_out doubles as the stage-1 valid bit.
      pixel_valid_out <= in_valid;
      if (in_valid) begin
        prod_r    <= prod_acc_c;
        addend_r  <= addend_c;
        pixel_out <= pixel_in;
      end
      psum_valid_out <= pixel_valid_out;
      if (pixel_valid_out) begin
        psum_out <= sum_c;
        sat_flag <= sat_c;
      end
    end
  end

endmodule

// File: doc/pe_mac_ws_dbuf.md
# pe_mac_ws_dbuf

Parametrised weight-stationary systolic MAC processing element with a double-buffered weight register, signed/unsigned arithmetic, valid tracking and an optional saturating accumulator. Drop-in successor PE for the systolic array.
- Next weight tile shifts into the shadow register while the active weight keeps computing.
- Psum source is selected per sample: upstream chain, memory (K-tiling) or zero.
- Fixed 2-stage pipeline: multiply, then add.

## Interface
- `DATA_W`, default 8: pixel and weight width.
- `ACC_W`, default 32: psum width; must be ≥ 2·DATA_W.
- `SIGNED`, default 1: 1 = two's-complement operands; 0 = unsigned.

- `clk`  in  1  rising-edge clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global advance; 0 = every register holds.
- `w_load`  in  1  shadow ← `w_in`.
- `w_in`  in  DATA_W  weight from neighbour/loader.
- `w_swap`  in  1  active ← shadow.
- `w_out`  out  DATA_W  shadow register value, forming the weight shift chain.
- `in_valid`  in  1  qualifies `pixel_in` and the psum controls.
- `pixel_in`  in  DATA_W  activation.
- `psum_in`  in  ACC_W  upstream psum.
- `psum_mem_in`  in  ACC_W  psum base from memory.
- `psum_sel`  in  1  0 = `psum_in`; 1 = `psum_mem_in`.
- `clr`  in  1  addend forced to 0; overrides `psum_sel`.
- `pixel_out`  out  DATA_W  registered pixel to the next PE.
- `pixel_valid_out`  out  1  registered `in_valid`.
- `psum_out`  out  ACC_W  accumulated result.
- `psum_valid_out`  out  1  `psum_out` holds a new result.
- `sat_flag`  out  1  the current `psum_out` was clamped.

## Operation
- **Reset:** `rst`=1 at an edge zeroes every register, whatever `en` is. Active weight, shadow weight, product, addend and all outputs become 0.
- **Stall:** `en`=0 means no register changes. `w_load`, `w_swap` and `in_valid` are ignored.
- **Weight path (`en`=1):**
  - `w_load` writes the shadow; `w_swap` copies shadow → active.
  - Both together: active gets the old shadow and shadow gets `w_in`.
  - A multiply sampled on a swap edge uses the old active weight.
- **Stage 1 (`en`=1, `in_valid`=1):**
  - prod_r ← pixel_in × active weight, full 2·DATA_W, sign-extended if `SIGNED` else zero-extended to ACC_W.
  - addend_r ← 0 if `clr`, else `psum_mem_in` if `psum_sel`, else `psum_in`.
  - `pixel_out` ← `pixel_in`.
- **Stage 2:** when stage-1 valid, `psum_out` ← addend_r + prod_r.
- **Valid bits:** with `en`=1, both valid bits update every edge. Data registers load only on valid, so `psum_out` and `pixel_out` hold their last value while the valid bits drop.
- **Arithmetic:** the add is ACC_W-bit; behaviour on overflow is set by the `Configuration` section.

## Timing
- **Latency:** inputs sampled at edge N produce `psum_out` and `psum_valid_out` after edge N+1. `pixel_out` and `pixel_valid_out` appear after edge N.
- **Throughput:** one sample per enabled cycle, back-to-back, no bubbles.
- **Weight timing:** `w_out` updates the edge after `w_load`. A weight swapped at edge N is used by samples taken at edge N+1 onward.
- **Stall:** an `en`=0 gap of any length stretches latency by exactly its length. No sample is lost or duplicated.
- **Reset mid-stream:** in-flight samples are discarded; the first valid output follows the first valid input after reset.

## Configuration
- **`PE_SAT_EN` defined:**
  - Signed overflow is detected when both operands have the same sign and the result differs; it clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - Unsigned carry-out clamps to 2^ACC_W−1.
  - `sat_flag` is registered with `psum_out` and valid with `psum_valid_out`.
- **Undefined:** the add wraps modulo 2^ACC_W and `sat_flag` is tied 0. The port remains either way.

## Test plan
All scenarios use DATA_W=8, ACC_W=32, SIGNED=1.
- **Reset:** hold `rst`=1 for 2 edges with random inputs and `en`=1 → every output is 0; `psum_valid_out`=0.
- **Basic MAC:** load 10, swap, then `pixel_in`=5, `psum_in`=0 valid at edge N → `psum_out`=50, valid after N+1. Next, `pixel_in`=3, `psum_in`=100 → 130.
- **Signed / clear:** w=0xFD (−3), `pixel_in`=7, `psum_in`=100 → 79. Same with `clr`=1 → 0xFFFFFFEB (−21).
- **Double buffer:** active 10, stream `pixel_in`=4 and `w_load` 2 → 40. Swap on the same edge as the next 4 → 40. Following 4 → 8. `w_out`=2 throughout after the load.
- **Stall:** during the stream 5, 3, 2 (w=10, `psum_in`=0), drop `en` for 3 cycles after the second sample → outputs hold. On resume, the results 50, 30, 20 arrive in order and none is duplicated.
- **Saturation (K-tiling):** `psum_sel`=1, `psum_mem_in`=0x7FFFFFF0, w=127, `pixel_in`=127 → with `PE_SAT_EN`, 0x7FFFFFFF and `sat_flag`=1. Without it, 0x80003EF1 and `sat_flag`=0.
